regfile_bypass_scoreboard: RTL and testbench

Register-file end of the writeback path: stores the 16-bit value selected by the writeback stage and serves the decode stage's two read ports. Contains write-to-read bypass, so decode sees a same-cycle writeback, and a per-register pending-write scoreboard. The scoreboard raises stall requests while a source register still has an in-flight producer. Sits between decode (read/issue side) and writeback (write side) of the pipelined core.

---
 rtl/regfile_bypass_scoreboard.sv | 108 ++++++++++
 tb/tb_regfile_bypass_scoreboard.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass_scoreboard.sv
// regfile_bypass_scoreboard
//
// Register file at the end of the writeback path. It stores writeback values,
// serves the decode stage's two read ports with same-cycle write-to-read
// bypass, and keeps a per-register pending-write counter. The counters drive
// stall requests for sources whose producer is still in flight.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   read1RegSel/Valid    source 1 select and "source is used" qualifier
//   read2RegSel/Valid    source 2 select and "source is used" qualifier
//   read1Data/read2Data  combinational read data (bypassed from writeback)
//   writeEn/RegSel/Data  writeback commit
//   issueEn/issueRegSel  an issuing instruction will later write issueRegSel
//   stall1/stall2        source N still has an outstanding producer
//   err                  sticky counter overflow/underflow flag
module regfile_bypass_scoreboard #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int CNTW  = 2,
    localparam int SELW = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SELW-1:0]  read1RegSel,
    input  logic [SELW-1:0]  read2RegSel,
    input  logic             read1Valid,
    input  logic             read2Valid,
    output logic [WIDTH-1:0] read1Data,
    output logic [WIDTH-1:0] read2Data,
    input  logic             writeEn,
    input  logic [SELW-1:0]  writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    input  logic             issueEn,
    input  logic [SELW-1:0]  issueRegSel,
    output logic             stall1,
    output logic             stall2,
    output logic             err
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [WIDTH-1:0] regs [NREG];
    logic [CNTW-1:0]  cnt  [NREG];
    logic [CNTW-1:0]  cnt_nxt [NREG];
    logic             err_set;

    // Saturating counter step. Returns {error, next}; an increment at the
    // ceiling or a decrement at zero holds the value and flags an error.
    function automatic logic [CNTW:0] cnt_step(input logic [CNTW-1:0] cur,
                                               input logic inc,
                                               input logic dec);
        logic [CNTW:0] r;
        r = {1'b0, cur};
        if (inc && !dec) begin
            if (cur == CNT_MAX) r = {1'b1, cur};
            else                r = {1'b0, cur + CNT_ONE};
        end else if (dec && !inc) begin
            if (cur == '0) r = {1'b1, cur};
            else           r = {1'b0, cur - CNT_ONE};
        end
        return r;
    endfunction

    // Stall unless the only remaining producer is writing back this cycle,
    // in which case the bypass already supplies the value.
    function automatic logic stall_of(input logic valid,
                                      input logic [SELW-1:0] sel,
                                      input logic [CNTW-1:0] c);
        logic wb_hit;
        wb_hit = writeEn && (writeRegSel == sel);
        return valid && (c != '0) && !((c == CNT_ONE) && wb_hit);
    endfunction

    always_comb begin
        err_set = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            logic [CNTW:0] s;
            s = cnt_step(cnt[i],
                         issueEn && (issueRegSel == SELW'(i)),
                         writeEn && (writeRegSel == SELW'(i)));
            cnt_nxt[i] = s[CNTW-1:0];
            err_set    = err_set | s[CNTW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            err <= 1'b0;
        end else begin
            if (writeEn) regs[writeRegSel] <= writeData;
            for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
            if (err_set) err <= 1'b1;
        end
    end

    assign read1Data = (writeEn && writeRegSel == read1RegSel) ? writeData : regs[read1RegSel];
    assign read2Data = (writeEn && writeRegSel == read2RegSel) ? writeData : regs[read2RegSel];

    assign stall1 = stall_of(read1Valid, read1RegSel, cnt[read1RegSel]);
    assign stall2 = stall_of(read2Valid, read2RegSel, cnt[read2RegSel]);

endmodule

// File: tb/tb_regfile_bypass_scoreboard.sv
// Directed bench for regfile_bypass_scoreboard: inputs change 1 ns after the
// rising edge, combinational outputs are sampled on the falling edge.
module tb_regfile_bypass_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  read1RegSel, read2RegSel, writeRegSel, issueRegSel;
    logic        read1Valid, read2Valid, writeEn, issueEn;
    logic [15:0] read1Data, read2Data, writeData;
    logic        stall1, stall2, err;

    int nvec = 0;
    int nmis = 0;

    regfile_bypass_scoreboard #(.WIDTH(16), .NREG(8), .CNTW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .read1Valid(read1Valid), .read2Valid(read2Valid),
        .read1Data(read1Data), .read2Data(read2Data),
        .writeEn(writeEn), .writeRegSel(writeRegSel), .writeData(writeData),
        .issueEn(issueEn), .issueRegSel(issueRegSel),
        .stall1(stall1), .stall2(stall2), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] ws, input logic [15:0] wd,
                         input logic ie, input logic [2:0] is,
                         input logic r1v, input logic [2:0] r1s,
                         input logic r2v, input logic [2:0] r2s);
        writeEn = we; writeRegSel = ws; writeData = wd;
        issueEn = ie; issueRegSel = is;
        read1Valid = r1v; read1RegSel = r1s;
        read2Valid = r2v; read2RegSel = r2s;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 16'h0, 0, 0, 1, 3'd1, 1, 3'd2);
        to_neg();
        chk("rst_rd1", read1Data, 16'h0);
        chk("rst_stall1", stall1, 1'b0);
        chk("rst_err", err, 1'b0);
        to_next();
        to_next();
        rst_n = 1'b1;
        to_next();

        // Write/read with bypass (producer for r3 issued first)
        drive(0, 0, 16'h0, 1, 3'd3, 1, 3'd3, 0, 3'd0);
        to_neg(); chk("iss_same_cycle_nostall", stall1, 1'b0); to_next();
        drive(1, 3'd3, 16'hBEEF, 0, 0, 1, 3'd3, 1, 3'd4);
        to_neg();
        chk("bypass_rd1", read1Data, 16'hBEEF);
        chk("bypass_rd2_other", read2Data, 16'h0);
        chk("bypass_stall1_last", stall1, 1'b0);
        chk("stall2_idle", stall2, 1'b0);
        to_next();
        drive(0, 0, 16'h0, 0, 0, 1, 3'd3, 0, 3'd0);
        to_neg();
        chk("stored_rd1", read1Data, 16'hBEEF);
        chk("stored_stall1", stall1, 1'b0);
        to_next();

        // Single producer stall on r2
        drive(0, 0, 16'h0, 1, 3'd2, 1, 3'd2, 0, 3'd2);
        to_neg(); chk("sb_c0_stall1", stall1, 1'b0); to_next();
        drive(0, 0, 16'h0, 0, 0, 1, 3'd2, 0, 3'd2);
        to_neg();
        chk("sb_c1_stall1", stall1, 1'b1);
        chk("sb_c1_stall2_invalid", stall2, 1'b0);
        to_next();
        to_neg(); chk("sb_c2_stall1", stall1, 1'b1); to_next();
        drive(1, 3'd2, 16'h0042, 0, 0, 1, 3'd2, 0, 3'd2);
        to_neg();
        chk("sb_c3_stall1", stall1, 1'b0);
        chk("sb_c3_rd1", read1Data, 16'h0042);
        to_next();
        drive(0, 0, 16'h0, 0, 0, 1, 3'd2, 0, 3'd2);
        to_neg();
        chk("sb_c4_stall1", stall1, 1'b0);
        chk("sb_c4_rd1", read1Data, 16'h0042);
        to_next();

        // Two producers on r6
        drive(0, 0, 16'h0, 1, 3'd6, 1, 3'd6, 0, 0);
        to_next();
        to_neg(); chk("mp_cnt1_stall1", stall1, 1'b1); to_next();
        drive(1, 3'd6, 16'h1111, 0, 0, 1, 3'd6, 0, 0);
        to_neg();
        chk("mp_wb1_stall1", stall1, 1'b1);
        chk("mp_wb1_rd1", read1Data, 16'h1111);
        to_next();
        drive(1, 3'd6, 16'h2222, 0, 0, 1, 3'd6, 1, 3'd6);
        to_neg();
        chk("mp_wb2_stall1", stall1, 1'b0);
        chk("mp_wb2_stall2", stall2, 1'b0);
        chk("mp_wb2_rd2", read2Data, 16'h2222);
        to_next();
        drive(0, 0, 16'h0, 0, 0, 1, 3'd6, 0, 0);
        to_neg(); chk("mp_after_stall1", stall1, 1'b0); to_next();

        // Simultaneous issue and writeback to r1 at cnt=1
        drive(0, 0, 16'h0, 1, 3'd1, 0, 0, 0, 0);
        to_next();
        drive(1, 3'd1, 16'h0A0A, 1, 3'd1, 1, 3'd1, 0, 0);
        to_neg();
        chk("sim_rd1", read1Data, 16'h0A0A);
        chk("sim_stall1", stall1, 1'b0);
        to_next();
        drive(0, 0, 16'h0, 0, 0, 1, 3'd1, 0, 0);
        to_neg();
        chk("sim_next_stall1", stall1, 1'b1);
        chk("sim_next_err", err, 1'b0);
        to_next();
        drive(1, 3'd1, 16'h0B0B, 0, 0, 1, 3'd1, 0, 0);
        to_next();
        drive(0, 0, 16'h0, 0, 0, 1, 3'd1, 0, 0);
        to_neg();
        chk("drain_stall1", stall1, 1'b0);
        chk("pre_err", err, 1'b0);
        to_next();

        // Overflow: four issues to r7
        drive(0, 0, 16'h0, 1, 3'd7, 1, 3'd7, 0, 0);
        to_next(); to_next(); to_next();
        to_neg(); chk("ovf_pre_err", err, 1'b0); to_next();
        drive(1, 3'd7, 16'h7001, 0, 0, 1, 3'd7, 0, 0);
        to_neg();
        chk("ovf_err", err, 1'b1);
        chk("ovf_cnt3_stall1", stall1, 1'b1);
        to_next();
        drive(1, 3'd7, 16'h7002, 0, 0, 1, 3'd7, 0, 0);
        to_neg(); chk("ovf_cnt2_stall1", stall1, 1'b1); to_next();
        drive(1, 3'd7, 16'h7003, 0, 0, 1, 3'd7, 0, 0);
        to_neg(); chk("ovf_cnt1_stall1", stall1, 1'b0); to_next();
        drive(0, 0, 16'h0, 0, 0, 1, 3'd7, 0, 0);
        to_neg();
        chk("ovf_cnt0_stall1", stall1, 1'b0);
        chk("ovf_err_sticky", err, 1'b1);
        to_next();

        // Leave r5 pending, then reset mid-run
        drive(1, 3'd5, 16'h5555, 1, 3'd5, 0, 0, 0, 0);
        to_next();
        drive(0, 0, 16'h0, 1, 3'd5, 1, 3'd3, 1, 3'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_rd1", read1Data, 16'h0);
        chk("mrst_rd2", read2Data, 16'h0);
        chk("mrst_stall2", stall2, 1'b0);
        chk("mrst_err", err, 1'b0);
        to_next();
        drive(0, 0, 16'h0, 0, 0, 1, 3'd5, 1, 3'd7);
        rst_n = 1'b1;
        to_neg();
        chk("post_rst_rd_r5", read1Data, 16'h0);
        chk("post_rst_stall1", stall1, 1'b0);
        chk("post_rst_rd_r7", read2Data, 16'h0);
        to_next();

        // Underflow: writeback to r0 with no producer
        drive(1, 3'd0, 16'h00C0, 0, 0, 1, 3'd0, 0, 0);
        to_neg();
        chk("udf_bypass_rd", read1Data, 16'h00C0);
        chk("udf_pre_err", err, 1'b0);
        to_next();
        drive(0, 0, 16'h0, 0, 0, 1, 3'd0, 0, 0);
        to_neg();
        chk("udf_err", err, 1'b1);
        chk("udf_r0_written", read1Data, 16'h00C0);
        chk("udf_cnt0_stall1", stall1, 1'b0);
        to_next();
        to_neg(); chk("udf_err_sticky", err, 1'b1); to_next();
        rst_n = 1'b0;
        #1;
        chk("err_cleared", err, 1'b0);
        to_next();
        rst_n = 1'b1;
        to_next();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
